// File: rtl/core_ctrl_if.sv
// ----------------------------------------------------------------------------
// core_ctrl_if
//
// Purpose: groups the control-sequencer signals that run between the glorb
// core datapath (Pc, Im, Alu, register file, data memory) and core_ctrl.
//
// Modports:
//   master - core_ctrl: samples go/instruction/zero_flag/mem_ready and drives
//            every enable, the memory handshake, status and debug outputs.
//   slave  - datapath side: drives the inputs, consumes the enables.
//
// Signals:
//   go           starts execution from IDLE
//   instruction  current Im output, opcode in [7:5]
//   zero_flag    registered ALU zero flag
//   mem_ready    data-memory completion for the current mem_req
//   pc_en        PC advances or loads at the next edge
//   pc_load      with pc_en, PC loads instruction[3:0] (branch_taken)
//   ir_load      instruction-register / operand latch enable
//   flag_we      ALU flag register write
//   rf_we        register file write to rd
//   wb_sel       writeback source: 0 = ALU out, 1 = memory read data
//   mem_req      data-memory access in progress
//   mem_we       with mem_req: 1 = store, 0 = load
//   halted       core stopped (HALT or FAULT)
//   fault        memory timeout occurred, sticky until reset
//   retired      completed-instruction count (CNT_W bits, wrapping)
//   state        current sequencer state, for debug
// ----------------------------------------------------------------------------
interface core_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             go;
    logic [7:0]       instruction;
    logic             zero_flag;
    logic             mem_ready;

    logic             pc_en;
    logic             pc_load;
    logic             ir_load;
    logic             flag_we;
    logic             rf_we;
    logic             wb_sel;
    logic             mem_req;
    logic             mem_we;
    logic             halted;
    logic             fault;
    logic [CNT_W-1:0] retired;
    logic [2:0]       state;

    modport master (
        input  go, instruction, zero_flag, mem_ready,
        output pc_en, pc_load, ir_load, flag_we, rf_we, wb_sel,
               mem_req, mem_we, halted, fault, retired, state
    );

    modport slave (
        output go, instruction, zero_flag, mem_ready,
        input  pc_en, pc_load, ir_load, flag_we, rf_we, wb_sel,
               mem_req, mem_we, halted, fault, retired, state
    );
endinterface

// File: rtl/core_ctrl.sv
// ----------------------------------------------------------------------------
// core_ctrl
//
// Purpose: multi-cycle control sequencer for the 8-bit glorb core. Latches the
// fetched opcode and steps FETCH -> DECODE -> EXEC/MEM -> WB, driving the PC,
// register file, flag and data-memory enables. Memory accesses that stay
// unready for MEM_TIMEOUT consecutive cycles put the core into FAULT.
//
// Parameters:
//   MEM_TIMEOUT  consecutive mem_ready-low MEM cycles before FAULT (1..255)
//   CNT_W        width of the retired-instruction counter
//
// Ports:
//   clk      core clock, rising edge
//   startup  asynchronous active-high reset
//   bus      core_ctrl_if.master (inputs go/instruction/zero_flag/mem_ready,
//            all enables, handshake, status and debug state)
// ----------------------------------------------------------------------------
module core_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic        clk,
    input  logic        startup,
    core_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_FAULT  = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        OP_ALU_REG = 3'b000,
        OP_ALU_IMM = 3'b001,
        OP_LOAD    = 3'b010,
        OP_STORE   = 3'b011,
        OP_BEQZ    = 3'b100,
        OP_JMP     = 3'b101,
        OP_NOP     = 3'b110,
        OP_HALT    = 3'b111
    } op_t;

    // Wait-counter value on the last tolerated unready MEM cycle; one more
    // unready cycle would make it reach MEM_TIMEOUT.
    localparam logic [7:0] LP_WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t           r_state;
    state_t           w_next_state;
    op_t              r_opcode;
    logic [7:0]       r_wait;
    logic [7:0]       w_wait_next;
    logic [CNT_W-1:0] r_retired;

    logic w_pc_en;
    logic w_pc_load;
    logic w_ir_load;
    logic w_flag_we;
    logic w_rf_we;
    logic w_wb_sel;
    logic w_mem_req;
    logic w_mem_we;
    logic w_halted;
    logic w_fault;
    logic w_retire;

    // ------------------------------------------------------------------------
    // State, opcode latch, wait counter and retired counter
    // ------------------------------------------------------------------------
    // NOTE: every register here is updated with non-blocking assignments so
    // all of them sample the pre-edge values of each other, like real flops.
    always_ff @(posedge clk or posedge startup) begin
        if (startup) begin
            r_state   <= S_IDLE;
            r_opcode  <= OP_ALU_REG;
            r_wait    <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_next_state;
            r_wait  <= w_wait_next;
            if (r_state == S_FETCH) begin
                r_opcode <= op_t'(bus.instruction[7:5]);
            end
            if (w_retire) begin
                r_retired <= r_retired + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------------
    // NOTE: every signal written below gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_wait_next  = '0;
        w_pc_en      = 1'b0;
        w_pc_load    = 1'b0;
        w_ir_load    = 1'b0;
        w_flag_we    = 1'b0;
        w_rf_we      = 1'b0;
        w_wb_sel     = 1'b0;
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        w_halted     = 1'b0;
        w_fault      = 1'b0;
        w_retire     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.go) begin
                    w_next_state = S_FETCH;
                end
            end

            S_FETCH: begin
                w_ir_load    = 1'b1;
                w_next_state = S_DECODE;
            end

            S_DECODE: begin
                case (r_opcode)
                    OP_NOP: begin
                        w_pc_en      = 1'b1;
                        w_next_state = S_FETCH;
                    end
                    OP_JMP: begin
                        w_pc_en      = 1'b1;
                        w_pc_load    = 1'b1;
                        w_next_state = S_FETCH;
                    end
                    OP_BEQZ: begin
                        // Branch decision is the only DECODE output that
                        // looks at a live input.
                        w_pc_en      = 1'b1;
                        w_pc_load    = bus.zero_flag;
                        w_next_state = S_FETCH;
                    end
                    OP_ALU_REG, OP_ALU_IMM: begin
                        w_next_state = S_EXEC;
                    end
                    OP_LOAD, OP_STORE: begin
                        w_next_state = S_MEM;
                    end
                    OP_HALT: begin
                        // HALT counts as retired even though the PC stays.
                        w_retire     = 1'b1;
                        w_next_state = S_HALT;
                    end
                endcase
            end

            S_EXEC: begin
                w_flag_we    = 1'b1;
                w_next_state = S_WB;
            end

            S_MEM: begin
                w_mem_req = 1'b1;
                w_mem_we  = (r_opcode == OP_STORE);
                if (bus.mem_ready) begin
                    // Ready wins over a timeout landing in the same cycle.
                    if (r_opcode == OP_STORE) begin
                        w_pc_en      = 1'b1;
                        w_next_state = S_FETCH;
                    end else begin
                        w_next_state = S_WB;
                    end
                end else if (r_wait == LP_WAIT_LAST) begin
                    w_next_state = S_FAULT;
                end else begin
                    w_wait_next = r_wait + 1'b1;
                end
            end

            S_WB: begin
                w_rf_we      = 1'b1;
                w_pc_en      = 1'b1;
                w_wb_sel     = (r_opcode == OP_LOAD);
                w_next_state = S_FETCH;
            end

            S_HALT: begin
                w_halted = 1'b1;
            end

            S_FAULT: begin
                w_halted = 1'b1;
                w_fault  = 1'b1;
            end
        endcase

        // Every PC step retires exactly one instruction.
        w_retire = w_retire | w_pc_en;
    end

    // ------------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------------
    assign bus.pc_en   = w_pc_en;
    assign bus.pc_load = w_pc_load;
    assign bus.ir_load = w_ir_load;
    assign bus.flag_we = w_flag_we;
    assign bus.rf_we   = w_rf_we;
    assign bus.wb_sel  = w_wb_sel;
    assign bus.mem_req = w_mem_req;
    assign bus.mem_we  = w_mem_we;
    assign bus.halted  = w_halted;
    assign bus.fault   = w_fault;
    assign bus.retired = r_retired;
    assign bus.state   = r_state;

endmodule
